// File: rtl/bch_ctrl_pkg.sv
// Shared types and helpers for the BCH frame controller: FSM state encoding,
// statistics counter width and the popcount result width.
package bch_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int CNT_W = 16;

  // Bits needed to count 0..n set bits of an n-bit mask.
  function automatic int flip_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bch_ctrl_fifo.sv
// In-flight frame FIFO: first-word-fall-through head, simultaneous push and pop
// allowed even when full (the slot being read is the one being overwritten).
module bch_ctrl_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/bch_frame_ctrl.sv
// BCH test-frame controller: holds one source frame, launches it into the codec,
// queues the expected message and scores decoder results against it.
module bch_frame_ctrl
  import bch_ctrl_pkg::*;
#(
  parameter int N     = 31,
  parameter int K     = 11,
  parameter int T     = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [K-1:0]     src_data,
  input  logic [N-1:0]     src_error,
  input  logic             codec_ready,
  output logic             codec_start,
  output logic [K-1:0]     codec_data,
  output logic [N-1:0]     codec_error,
  input  logic             dec_valid,
  input  logic [K-1:0]     dec_data,
  output logic             wrong_now,
  output logic             wrong,
  output logic [CNT_W-1:0] frames_done,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             busy
);

  localparam int             FW    = flip_w(N);
  localparam logic [FW-1:0]  T_LIM = FW'(T);

  state_t           state_reg;
  logic [K-1:0]     hold_data_reg;
  logic [N-1:0]     hold_error_reg;
  logic [FW-1:0]    flip_cnt_reg;
  logic [K-1:0]     codec_data_reg;
  logic [N-1:0]     codec_error_reg;
  logic             wrong_now_reg;
  logic             wrong_reg;
  logic [CNT_W-1:0] frames_done_reg;
  logic [CNT_W-1:0] fail_cnt_reg;

  logic             fifo_full;
  logic             fifo_empty;
  logic [K:0]       fifo_head;
  logic             accept;
  logic             launch;
  logic             hit;
  logic             miss;

  // Running popcount of the error mask, one adder stage per bit.
  logic [FW-1:0] psum [N+1];
  assign psum[0] = '0;
  for (genvar gi = 0; gi < N; gi++) begin : g_pop
    assign psum[gi+1] = psum[gi] + FW'(src_error[gi]);
  end

  assign src_ready = (state_reg == IDLE) && !fifo_full;
  assign accept    = src_valid && src_ready;
  // Launch is suppressed in a reset cycle so no strobe escapes while state is cleared.
  assign launch    = (state_reg == HOLD) && codec_ready && !reset;

  assign codec_start = launch;
  assign codec_data  = launch ? hold_data_reg  : codec_data_reg;
  assign codec_error = launch ? hold_error_reg : codec_error_reg;

  // Head layout: message in the upper bits, uncorrectable flag in bit 0.
  assign hit  = dec_valid && !fifo_empty;
  assign miss = dec_valid && (fifo_empty ||
                ((dec_data != fifo_head[K:1]) && !fifo_head[0]));

  bch_ctrl_fifo #(
    .W     (K + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (launch),
    .push_data ({hold_data_reg, (flip_cnt_reg > T_LIM)}),
    .pop       (dec_valid),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      hold_data_reg   <= '0;
      hold_error_reg  <= '0;
      flip_cnt_reg    <= '0;
      codec_data_reg  <= '0;
      codec_error_reg <= '0;
      wrong_now_reg   <= 1'b0;
      wrong_reg       <= 1'b0;
      frames_done_reg <= '0;
      fail_cnt_reg    <= '0;
    end else begin
      if (accept) begin
        state_reg      <= HOLD;
        hold_data_reg  <= src_data;
        hold_error_reg <= src_error;
        flip_cnt_reg   <= psum[N];
      end else if (launch) begin
        state_reg       <= IDLE;
        codec_data_reg  <= hold_data_reg;
        codec_error_reg <= hold_error_reg;
      end
      wrong_now_reg <= miss;
      if (miss) wrong_reg <= 1'b1;
      if (hit && (frames_done_reg != '1)) frames_done_reg <= frames_done_reg + CNT_W'(1);
      if (miss && (fail_cnt_reg != '1))   fail_cnt_reg    <= fail_cnt_reg + CNT_W'(1);
    end
  end

  assign wrong_now   = wrong_now_reg;
  assign wrong       = wrong_reg;
  assign frames_done = frames_done_reg;
  assign fail_cnt    = fail_cnt_reg;
  assign busy        = (state_reg == HOLD) || !fifo_empty;

endmodule

// File: tb/tb_bch_frame_ctrl.sv
// Scoreboard bench for bch_frame_ctrl: a frame-level model queues expected
// launches and decode results; a negedge monitor pops and compares them.
module tb_bch_frame_ctrl;

  localparam int N = 31;
  localparam int K = 11;
  localparam int T = 5;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          src_valid;
  logic          src_ready;
  logic [K-1:0]  src_data;
  logic [N-1:0]  src_error;
  logic          codec_ready;
  logic          codec_start;
  logic [K-1:0]  codec_data;
  logic [N-1:0]  codec_error;
  logic          dec_valid;
  logic [K-1:0]  dec_data;
  logic          wrong_now;
  logic          wrong;
  logic [15:0]   frames_done;
  logic [15:0]   fail_cnt;
  logic          busy;

  bch_frame_ctrl #(.N(N), .K(K), .T(T), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_data    (src_data),
    .src_error   (src_error),
    .codec_ready (codec_ready),
    .codec_start (codec_start),
    .codec_data  (codec_data),
    .codec_error (codec_error),
    .dec_valid   (dec_valid),
    .dec_data    (dec_data),
    .wrong_now   (wrong_now),
    .wrong       (wrong),
    .frames_done (frames_done),
    .fail_cnt    (fail_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { logic [K-1:0] data; logic [N-1:0] err; } frame_t;
  typedef struct { int cyc; logic [K-1:0] data; logic [N-1:0] err; } launch_t;
  typedef struct { int cyc; logic wn; logic wr; int done; int fail; } result_t;

  frame_t  m_fifo[$];
  frame_t  m_held;
  bit      m_has_held;
  bit      m_hs;
  int      m_done, m_fail;
  bit      m_wrong;
  bit      exp_src_ready, exp_busy;
  launch_t launch_q[$];
  result_t result_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] rand_mask(input int k);
    logic [N-1:0] m = '0;
    int placed = 0;
    while (placed < k) begin
      int b;
      b = $urandom_range(0, N - 1);
      if (!m[b]) begin
        m[b] = 1'b1;
        placed++;
      end
    end
    return m;
  endfunction

  // One clock of stimulus plus the frame-level model for that cycle.
  task automatic step(input logic sv, input logic [K-1:0] sd, input logic [N-1:0] se,
                      input logic cr, input logic dv, input logic [K-1:0] dd, input logic rst);
    result_t r;
    launch_t l;
    frame_t  h;
    @(posedge clk);
    #1;
    src_valid = sv; src_data = sd; src_error = se;
    codec_ready = cr; dec_valid = dv; dec_data = dd; reset = rst;
    exp_src_ready = !m_has_held && (m_fifo.size() < DEPTH);
    exp_busy      = m_has_held || (m_fifo.size() > 0);
    m_hs = 1'b0;
    if (rst) begin
      m_has_held = 1'b0;
      m_fifo.delete();
      launch_q.delete();
      result_q.delete();
      m_done = 0; m_fail = 0; m_wrong = 1'b0;
    end else begin
      if (dv) begin
        r.cyc = cyc + 1;
        if (m_fifo.size() == 0) begin
          r.wn = 1'b1;
        end else begin
          h = m_fifo.pop_front();
          m_done++;
          r.wn = (dd != h.data) && ($countones(h.err) <= T);
        end
        if (r.wn) begin
          m_fail++;
          m_wrong = 1'b1;
        end
        r.wr = m_wrong; r.done = m_done; r.fail = m_fail;
        result_q.push_back(r);
      end
      if (m_has_held && cr) begin
        l.cyc = cyc; l.data = m_held.data; l.err = m_held.err;
        launch_q.push_back(l);
        m_fifo.push_back(m_held);
        m_has_held = 1'b0;
      end else if (sv && exp_src_ready) begin
        m_held.data = sd; m_held.err = se;
        m_has_held = 1'b1;
        m_hs = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n, input logic cr);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, cr, 1'b0, '0, 1'b0);
  endtask

  task automatic send(input logic [K-1:0] d, input logic [N-1:0] e, input logic cr);
    bit took = 1'b0;
    for (int i = 0; i < 20 && !took; i++) begin
      step(1'b1, d, e, cr, 1'b0, '0, 1'b0);
      took = m_hs;
    end
    chk("send_handshake", took, 64'(took), 64'd1);
  endtask

  task automatic dec(input logic [K-1:0] d, input logic cr);
    step(1'b0, '0, '0, cr, 1'b1, d, 1'b0);
  endtask

  // Monitor: compares every presented output against the queued expectations.
  logic [K-1:0] last_data;
  logic [N-1:0] last_err;
  logic [15:0]  last_fd, last_fc;
  bit           rst_seen = 1'b0;
  bit           started = 1'b0;

  always @(negedge clk) begin : mon
    launch_t l;
    result_t r;
    if (reset === 1'b1) begin
      rst_seen = 1'b1;
      started  = 1'b1;
    end else if (started) begin
      if (rst_seen) begin
        rst_seen = 1'b0;
        chk("reset_codec", {codec_start, codec_data, codec_error} === '0,
            64'({codec_start, codec_data, codec_error}), 64'd0);
        chk("reset_status", {wrong_now, wrong, frames_done, fail_cnt, busy, src_ready} === {34'd0, 1'b1},
            64'({wrong_now, wrong, frames_done, fail_cnt, busy, src_ready}), 64'd1);
        last_data = '0; last_err = '0; last_fd = '0; last_fc = '0;
      end else begin
        chk("flow_ready_busy", {src_ready, busy} === {exp_src_ready, exp_busy},
            64'({src_ready, busy}), 64'({exp_src_ready, exp_busy}));
        if (codec_start === 1'b1) begin
          if (launch_q.size() == 0) begin
            chk("launch_unexpected", 1'b0, 64'(codec_data), 64'd0);
          end else begin
            l = launch_q.pop_front();
            $display("launch  cyc=%0d data=%h err=%h", cyc, codec_data, codec_error);
            chk("launch_cycle", cyc == l.cyc, 64'(cyc), 64'(l.cyc));
            chk("launch_payload", {codec_data, codec_error} === {l.data, l.err},
                64'({codec_data, codec_error}), 64'({l.data, l.err}));
            last_data = l.data; last_err = l.err;
          end
        end else begin
          chk("codec_hold", {codec_start, codec_data, codec_error} === {1'b0, last_data, last_err},
              64'({codec_data, codec_error}), 64'({last_data, last_err}));
        end
        if (wrong_now !== 1'b0 || frames_done !== last_fd || fail_cnt !== last_fc) begin
          if (result_q.size() == 0) begin
            chk("result_unexpected", 1'b0, 64'({wrong_now, frames_done, fail_cnt}), 64'd0);
          end else begin
            r = result_q.pop_front();
            $display("result  cyc=%0d wrong_now=%0b wrong=%0b done=%0d fail=%0d",
                     cyc, wrong_now, wrong, frames_done, fail_cnt);
            chk("result_cycle", cyc == r.cyc, 64'(cyc), 64'(r.cyc));
            chk("result_values", {wrong_now, wrong, frames_done, fail_cnt} === {r.wn, r.wr, 16'(r.done), 16'(r.fail)},
                64'({wrong_now, wrong, frames_done, fail_cnt}), 64'({r.wn, r.wr, 16'(r.done), 16'(r.fail)}));
          end
          last_fd = frames_done; last_fc = fail_cnt;
        end
      end
    end
  end

  initial begin
    logic [K-1:0] rd;
    reset = 1'b1; src_valid = 1'b0; src_data = '0; src_error = '0;
    codec_ready = 1'b0; dec_valid = 1'b0; dec_data = '0;
    m_has_held = 1'b0; m_done = 0; m_fail = 0; m_wrong = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);

    // Single correctable frame, decoder returns the original message.
    send(11'h5A3, rand_mask(2), 1'b1);
    idle(2, 1'b1);
    dec(11'h5A3, 1'b1);
    idle(2, 1'b1);

    // Correctable frame decoded wrongly.
    send(11'h5A3, rand_mask(3), 1'b1);
    idle(2, 1'b1);
    dec(11'h5A2, 1'b1);
    idle(3, 1'b1);

    // Uncorrectable frame: garbage from the decoder is not a failure.
    send(11'h1C4, rand_mask(6), 1'b1);
    idle(1, 1'b1);
    dec(11'h7FF, 1'b1);
    idle(2, 1'b1);

    // Fill the FIFO, then pop and refill; pop and launch in the same cycle.
    for (int i = 0; i < 4; i++) begin
      send(11'(100 + i), rand_mask(i), 1'b1);
      idle(1, 1'b1);
    end
    idle(2, 1'b1);
    dec(m_fifo[0].data, 1'b1);
    send(11'h0F0, rand_mask(1), 1'b1);
    idle(2, 1'b1);
    dec(m_fifo[0].data, 1'b1);
    send(11'h0F1, rand_mask(4), 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1, m_fifo[0].data, 1'b0);
    idle(1, 1'b1);
    while (m_fifo.size() > 0) dec(m_fifo[0].data, 1'b1);
    idle(2, 1'b1);

    // Underflow, then reset with a frame held and a decode in the reset cycle.
    dec(11'h123, 1'b1);
    idle(2, 1'b1);
    send(11'h2AA, rand_mask(2), 1'b0);
    idle(1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1, 11'h2AA, 1'b1);
    idle(3, 1'b1);
    dec(11'h2AA, 1'b1);
    idle(2, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rd = (m_fifo.size() > 0 && $urandom_range(0, 3) != 0) ? m_fifo[0].data : K'($urandom);
      step(1'($urandom_range(0, 1)), K'($urandom), rand_mask($urandom_range(0, 8)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), rd,
           1'($urandom_range(0, 149) == 0));
    end
    idle(5, 1'b1);

    chk("launch_q_drained", launch_q.size() == 0, 64'(launch_q.size()), 64'd0);
    chk("result_q_drained", result_q.size() == 0, 64'(result_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
